bus_arbiter: RTL and testbench
==============================

// Module: bus_arbiter
//
// PURPOSE
//   Round-robin arbiter sharing the 4:1 8-bit operand/result multiplexer
//   between four requesters (e.g. ALU, register file, memory, immediate unit).
//   Registers a one-hot grant and drives the multiplexer 'select' input, so
//   exactly one source owns the shared bus at a time.
//   A hold-time limit bounds bus ownership, so no requester can starve the others.
//
// PARAMETERS
//   MAX_HOLD   8   max consecutive cycles one owner keeps the bus while others wait (>=1)
//   CNT_W      4   width of hold counter; must satisfy 2**CNT_W >= MAX_HOLD
//
// PORTS
//   clk        in   1   system clock, all state updates on rising edge
//   rst        in   1   asynchronous, active-high reset
//   req        in   4   request vector, req[i]=1 -> requester i wants the bus
//   grant      out  4   one-hot registered grant (all-zero when idle)
//   select     out  2   index of current owner, wired to multiplexer select
//   bus_valid  out  1   1 when grant != 0 (mux output is driven by an owner)
//
// BEHAVIOUR
//   - Reset (async, immediate): grant=0, select=0, bus_valid=0, state=IDLE,
//     hold_cnt=0, priority pointer last=3 (so req[0] wins first arbitration).
//   - States: IDLE (no owner), OWNED (grant one-hot, select=owner index).
//   - Arbitration: search req circularly starting at last+1 mod 4; first set bit wins.
//     On every new grant: last<=winner, hold_cnt<=0.
//   - Latency: grant/select/bus_valid update 1 edge after the req change that
//     causes them. No combinational path from req to outputs.
//   - IDLE -> OWNED: at edge where req!=0; winner per arbitration.
//   - OWNED, req[owner]=1, hold_cnt<MAX_HOLD-1: keep grant, hold_cnt++.
//   - OWNED, req[owner]=1, hold_cnt==MAX_HOLD-1:
//       other req pending -> grant moves to next winner (owner excluded from search
//       since search starts at owner+1); none pending -> keep grant, hold_cnt<=0.
//   - OWNED, req[owner]=0: same edge rearbitrates among remaining req; winner
//     granted with no dead cycle; if req==0 -> IDLE, grant=0, bus_valid=0.
//   - select holds the last owner's index while IDLE (mux output stays stable);
//     only changes when a new grant is issued or on reset.
//   - MAX_HOLD=1: under contention, ownership rotates every cycle.
//   - Reset mid-ownership: outputs clear immediately without waiting for clk;
//     first grant after release follows the reset pointer (search from 0).
//   - Invariants (assert): $onehot0(grant); bus_valid==|grant;
//     grant!=0 -> grant[select]==1; hold_cnt never exceeds MAX_HOLD-1.
//
// TESTING
//   1. rst pulse, then req=4'b0001 -> after 1 edge grant=0001, select=0, bus_valid=1.
//   2. MAX_HOLD=4, req=4'b1111 held -> grant sequence 0,1,2,3,0 with each owner
//      exactly 4 cycles and no idle cycle between owners.
//   3. Owner 2 active, req changes 0100->1001 -> next edge grant=1000, select=3;
//      then req=0001 -> grant=0001, select=0; then req=0 -> grant=0, select stays 0.
//   4. Single requester req=4'b0010 for 20 cycles (MAX_HOLD=8) -> grant=0010
//      continuously, no gaps, hold_cnt wraps at 7.
//   5. Assert rst mid-ownership (grant=0100) between edges -> grant=0, select=0
//      before next edge; release, req=4'b1010 -> grant=0010 (pointer reset).
//   6. Integrate with multiplexer: random in0..in3 and random req for 200 cycles
//      -> whenever bus_valid, mux out == in[select]; invariants never fire.

Source files
------------

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for a 4:1 8-bit shared operand/result bus.
// Issues a registered one-hot grant and a select index for the mux.
// A hold limit caps how long one owner keeps the bus while others wait.
module bus_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] select,
  output logic       bus_valid
);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t           r_state;
  logic [1:0]       r_last;
  logic [CNT_W-1:0] r_hold;
  logic [3:0]       r_grant;
  logic [1:0]       r_sel;
  logic             r_valid;

  logic [1:0]       w_win;
  logic [1:0]       w_idx;
  logic             w_any;
  logic             w_others;
  logic             w_at_limit;
  logic             w_take;
  logic             w_drop;

  // Circular search from r_last+1; descending k lets the nearest requester win.
  // While owned, r_last is the owner, so the owner is always searched last.
  always_comb begin
    w_win = r_last + 2'd1;
    w_idx = '0;
    for (int k = 4; k >= 1; k--) begin
      w_idx = r_last + 2'(k);
      if (req[w_idx]) w_win = w_idx;
    end
  end

  assign w_any      = |req;
  assign w_others   = |(req & ~r_grant);
  assign w_at_limit = (r_hold == CNT_W'(MAX_HOLD - 1));

  // Decide whether this edge issues a new grant or releases the bus.
  always_comb begin
    w_take = 1'b0;
    w_drop = 1'b0;
    case (r_state)
      IDLE:  w_take = w_any;
      OWNED: begin
        if (req[r_sel]) begin
          w_take = w_at_limit & w_others;
        end else begin
          w_take = w_any;
          w_drop = ~w_any;
        end
      end
      default: w_take = 1'b0;
    endcase
  end

  // Arbiter FSM: all outputs registered; select is kept while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_last  <= 2'd3;
      r_hold  <= '0;
      r_grant <= '0;
      r_sel   <= '0;
      r_valid <= 1'b0;
    end else if (w_take) begin
      r_state <= OWNED;
      r_last  <= w_win;
      r_hold  <= '0;
      r_grant <= 4'b0001 << w_win;
      r_sel   <= w_win;
      r_valid <= 1'b1;
    end else if (w_drop) begin
      r_state <= IDLE;
      r_hold  <= '0;
      r_grant <= '0;
      r_valid <= 1'b0;
    end else if (r_state == OWNED) begin
      // Owner keeps the bus; counter restarts at the limit when nobody waits.
      r_hold <= w_at_limit ? '0 : r_hold + 1'b1;
    end
  end

  assign grant     = r_grant;
  assign select    = r_sel;
  assign bus_valid = r_valid;

  a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(r_grant));
  a_valid:  assert property (@(posedge clk) disable iff (rst) r_valid == (|r_grant));
  a_sel:    assert property (@(posedge clk) disable iff (rst) (r_grant != 0) |-> r_grant[r_sel]);
  a_hold:   assert property (@(posedge clk) disable iff (rst) r_hold <= CNT_W'(MAX_HOLD - 1));

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: directed steps push expected outputs,
// a monitor pops them one edge later; a random phase checks the bus mux.
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req_a = '0, req_b = '0, req_c = '0;
  logic [3:0] grant_a, grant_b, grant_c;
  logic [1:0] sel_a, sel_b, sel_c;
  logic       valid_a, valid_b, valid_c;
  logic [7:0] in_arr [4];
  logic [7:0] mux_out;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    int         id;
    logic [3:0] g;
    logic [1:0] s;
    logic       v;
    string      nm;
  } exp_t;

  exp_t sbq [$];

  always #5 clk = ~clk;

  bus_arbiter #(.MAX_HOLD(8), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst), .req(req_a),
    .grant(grant_a), .select(sel_a), .bus_valid(valid_a));
  bus_arbiter #(.MAX_HOLD(4), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .req(req_b),
    .grant(grant_b), .select(sel_b), .bus_valid(valid_b));
  bus_arbiter #(.MAX_HOLD(1), .CNT_W(4)) dut_c (
    .clk(clk), .rst(rst), .req(req_c),
    .grant(grant_c), .select(sel_c), .bus_valid(valid_c));

  // Shared 4:1 operand mux driven by instance A's select.
  assign mux_out = in_arr[sel_a];

  task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] exp_v);
    n_total++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got grant/sel/valid=%b expected %b", nm, act, exp_v);
  endtask

  function automatic logic [6:0] outs(input int id);
    case (id)
      0:       return {grant_a, sel_a, valid_a};
      1:       return {grant_b, sel_b, valid_b};
      default: return {grant_c, sel_c, valid_c};
    endcase
  endfunction

  // Apply a request vector to one instance and queue the response due next edge.
  task automatic step(input int id, input logic [3:0] r, input logic [3:0] eg,
                      input logic [1:0] es, input logic ev, input string nm);
    exp_t e;
    @(negedge clk);
    req_a = (id == 0) ? r : 4'b0;
    req_b = (id == 1) ? r : 4'b0;
    req_c = (id == 2) ? r : 4'b0;
    e.id = id; e.g = eg; e.s = es; e.v = ev; e.nm = nm;
    sbq.push_back(e);
    @(posedge clk);
  endtask

  // Monitor: registered outputs settle after the edge; compare one entry per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk(e.nm, outs(e.id), {e.g, e.s, e.v});
      end
    end
  end

  initial begin
    logic [3:0] req_prev;
    logic [7:0] exp_mux;
    logic [3:0] legal;
    for (int i = 0; i < 4; i++) in_arr[i] = 8'(i * 17);

    // Reset state on all instances
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_a", outs(0), 7'b0);
    chk("reset_b", outs(1), 7'b0);
    chk("reset_c", outs(2), 7'b0);
    rst = 1'b0;

    // First grant follows reset pointer
    step(0, 4'b0000, 4'b0000, 2'd0, 1'b0, "idle_stay");
    step(0, 4'b0001, 4'b0001, 2'd0, 1'b1, "first_grant");
    step(0, 4'b0000, 4'b0000, 2'd0, 1'b0, "release");

    // Owner drops: same-edge handoff, then idle keeps select
    step(0, 4'b0100, 4'b0100, 2'd2, 1'b1, "own2");
    step(0, 4'b1001, 4'b1000, 2'd3, 1'b1, "handoff3");
    step(0, 4'b0001, 4'b0001, 2'd0, 1'b1, "handoff0");
    step(0, 4'b0000, 4'b0000, 2'd0, 1'b0, "idle_sel0");

    // Lone requester keeps the bus across hold-counter wraps
    for (int k = 0; k < 20; k++)
      step(0, 4'b0010, 4'b0010, 2'd1, 1'b1, "single_hold");
    step(0, 4'b0000, 4'b0000, 2'd1, 1'b0, "idle_sel1");

    // MAX_HOLD=4, all requesting: each owner exactly 4 cycles, no gaps
    for (int k = 0; k < 17; k++)
      step(1, 4'b1111, 4'b0001 << ((k / 4) % 4), 2'((k / 4) % 4), 1'b1, "rr_hold4");
    step(1, 4'b0000, 4'b0000, 2'd0, 1'b0, "rr_hold4_idle");

    // MAX_HOLD=1: rotation every cycle
    for (int k = 0; k < 5; k++)
      step(2, 4'b1111, 4'b0001 << (k % 4), 2'(k % 4), 1'b1, "rr_hold1");
    step(2, 4'b0000, 4'b0000, 2'd0, 1'b0, "rr_hold1_idle");

    // Async reset mid-ownership, then pointer restarts at 0
    step(0, 4'b0100, 4'b0100, 2'd2, 1'b1, "own2_prerst");
    @(negedge clk);
    #2 rst = 1'b1;
    req_a = 4'b0000;
    #1 chk("async_reset", outs(0), 7'b0);
    @(negedge clk);
    rst = 1'b0;
    step(0, 4'b1010, 4'b0010, 2'd1, 1'b1, "post_reset_ptr");
    step(0, 4'b0000, 4'b0000, 2'd1, 1'b0, "post_reset_idle");

    // Random requests with the shared mux
    @(negedge clk);
    req_prev = 4'b0;
    for (int c = 0; c < 200; c++) begin
      if (c > 0) begin
        legal = {$onehot0(grant_a), valid_a == (|grant_a),
                 (grant_a & ~req_prev) == 4'b0, (req_prev == 4'b0) || (grant_a != 4'b0)};
        chk("rand_legal", {3'b0, legal}, 7'b0001111);
        if (valid_a) begin
          exp_mux = 8'h00;
          for (int i = 0; i < 4; i++) if (grant_a[i]) exp_mux = in_arr[i];
          chk("rand_mux", {1'b0, mux_out[7:2], 1'b0} | {6'b0, mux_out[1] ^ 1'b0},
              {1'b0, exp_mux[7:2], 1'b0} | {6'b0, exp_mux[1]});
          if (mux_out[0] !== exp_mux[0]) begin
            n_total++;
            $display("FAIL rand_mux_lsb: got %b expected %b", mux_out[0], exp_mux[0]);
          end
        end
      end
      req_a    = 4'($urandom);
      req_prev = req_a;
      for (int i = 0; i < 4; i++) in_arr[i] = 8'($urandom);
      @(negedge clk);
    end

    if (sbq.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
